// File: rtl/key_conditioner.sv
// Pushbutton conditioner: 2-flop synchroniser, per-key debounce FSM, press/release pulses, pause toggle.
// Latency: pin to key_level is 2 + DEBOUNCE_CYCLES clk cycles; pulses coincide with the level change; paused follows one cycle later.
// Backpressure: none; free-running input stage, outputs are registered levels and single-cycle pulses.
module key_conditioner #(
  parameter int N_KEYS          = 3,
  parameter int DEBOUNCE_CYCLES = 500000,
  parameter int CNT_W           = 20,
  parameter int PAUSE_IDX       = 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [N_KEYS-1:0] key_n,
  output logic [N_KEYS-1:0] key_level,
  output logic [N_KEYS-1:0] key_press,
  output logic [N_KEYS-1:0] key_release,
  output logic              paused
);

  typedef enum logic [1:0] {
    REL     = 2'd0,
    PRESS_W = 2'd1,
    PRS     = 2'd2,
    REL_W   = 2'd3
  } key_state_e;

  // Count value on the cycle that completes the required stable run.
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(DEBOUNCE_CYCLES - 1);
  // With a one-cycle debounce the first sample of a new value is already enough.
  localparam bit INSTANT = (DEBOUNCE_CYCLES == 1);

  logic [N_KEYS-1:0] sync1_q;
  logic [N_KEYS-1:0] sync2_q;
  logic [N_KEYS-1:0] s;

  key_state_e        state_q [N_KEYS];
  key_state_e        state_d [N_KEYS];
  logic [CNT_W-1:0]  cnt_q   [N_KEYS];
  logic [CNT_W-1:0]  cnt_d   [N_KEYS];

  logic [N_KEYS-1:0] level_q;
  logic [N_KEYS-1:0] level_d;
  logic [N_KEYS-1:0] press_q;
  logic [N_KEYS-1:0] release_q;
  logic              paused_q;

  // Synchronised pressed flag; inversion sits after the second flop so the
  // metastability path is pure flop-to-flop.
  assign s = ~sync2_q;

  // Two-stage synchroniser on the raw active-low pins; reset to "released".
  always_ff @(posedge clk) begin
    if (reset) begin
      sync1_q <= '1;
      sync2_q <= '1;
    end else begin
      sync1_q <= key_n;
      sync2_q <= sync1_q;
    end
  end

  // Per-key debounce next state: any disagreeing sample inside a wait state
  // drops back to the settled state and clears the run counter.
  always_comb begin
    for (int i = 0; i < N_KEYS; i++) begin
      state_d[i] = state_q[i];
      cnt_d[i]   = cnt_q[i];
      case (state_q[i])
        REL: begin
          if (s[i]) begin
            if (INSTANT) begin
              state_d[i] = PRS;
              cnt_d[i]   = '0;
            end else begin
              state_d[i] = PRESS_W;
              cnt_d[i]   = CNT_W'(1);
            end
          end
        end
        PRESS_W: begin
          if (!s[i]) begin
            state_d[i] = REL;
            cnt_d[i]   = '0;
          end else if (cnt_q[i] == LAST_CNT) begin
            state_d[i] = PRS;
            cnt_d[i]   = '0;
          end else begin
            cnt_d[i]   = cnt_q[i] + CNT_W'(1);
          end
        end
        PRS: begin
          if (!s[i]) begin
            if (INSTANT) begin
              state_d[i] = REL;
              cnt_d[i]   = '0;
            end else begin
              state_d[i] = REL_W;
              cnt_d[i]   = CNT_W'(1);
            end
          end
        end
        REL_W: begin
          if (s[i]) begin
            state_d[i] = PRS;
            cnt_d[i]   = '0;
          end else if (cnt_q[i] == LAST_CNT) begin
            state_d[i] = REL;
            cnt_d[i]   = '0;
          end else begin
            cnt_d[i]   = cnt_q[i] + CNT_W'(1);
          end
        end
        default: begin
          state_d[i] = REL;
          cnt_d[i]   = '0;
        end
      endcase
      level_d[i] = (state_d[i] == PRS) || (state_d[i] == REL_W);
    end
  end

  // Debounce state, registered level, edge pulses and the pause toggle.
  // Reset wins over everything, including a pulse that would land this cycle.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < N_KEYS; i++) begin
        state_q[i] <= REL;
        cnt_q[i]   <= '0;
      end
      level_q   <= '0;
      press_q   <= '0;
      release_q <= '0;
      paused_q  <= 1'b0;
    end else begin
      for (int i = 0; i < N_KEYS; i++) begin
        state_q[i] <= state_d[i];
        cnt_q[i]   <= cnt_d[i];
      end
      level_q   <= level_d;
      press_q   <= level_d & ~level_q;
      release_q <= ~level_d & level_q;
      paused_q  <= paused_q ^ press_q[PAUSE_IDX];
    end
  end

  assign key_level   = level_q;
  assign key_press   = press_q;
  assign key_release = release_q;
  assign paused      = paused_q;

endmodule

// File: tb/tb_key_conditioner.sv
// Bench for key_conditioner with DEBOUNCE_CYCLES=4: directed scenarios plus random key activity.
// Every cycle is compared against a run-length reference model of the debounce rules.
module tb_key_conditioner;

  localparam int NK = 3;
  localparam int DC = 4;

  logic          clk = 1'b0;
  logic          reset;
  logic [NK-1:0] key_n;
  logic [NK-1:0] key_level;
  logic [NK-1:0] key_press;
  logic [NK-1:0] key_release;
  logic          paused;

  int total = 0;
  int bad   = 0;

  // Reference model state: two-deep pin history, accepted level, length of the
  // current run of samples that disagree with the accepted level.
  logic [NK-1:0] m_h1, m_h2, m_lvl, m_prs, m_rel;
  logic          m_paused;
  int            m_run [NK];

  key_conditioner #(
    .N_KEYS(NK), .DEBOUNCE_CYCLES(DC), .CNT_W(20), .PAUSE_IDX(1)
  ) dut (
    .clk(clk), .reset(reset), .key_n(key_n),
    .key_level(key_level), .key_press(key_press),
    .key_release(key_release), .paused(paused)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  // Advance one clock, update the model from the inputs seen at that edge,
  // then compare all outputs shortly after the edge.
  task automatic step();
    logic [NK-1:0] pressed_now;
    logic [NK-1:0] new_lvl;
    @(posedge clk);
    if (reset) begin
      m_h1 = '1; m_h2 = '1; m_lvl = '0; m_prs = '0; m_rel = '0; m_paused = 1'b0;
      for (int k = 0; k < NK; k++) m_run[k] = 0;
    end else begin
      pressed_now = ~m_h2;
      new_lvl = m_lvl;
      for (int k = 0; k < NK; k++) begin
        if (pressed_now[k] != m_lvl[k]) begin
          m_run[k] = m_run[k] + 1;
          if (m_run[k] == DC) begin
            new_lvl[k] = ~m_lvl[k];
            m_run[k] = 0;
          end
        end else begin
          m_run[k] = 0;
        end
      end
      m_paused = m_paused ^ m_prs[1];
      m_prs = new_lvl & ~m_lvl;
      m_rel = ~new_lvl & m_lvl;
      m_lvl = new_lvl;
      m_h2 = m_h1;
      m_h1 = key_n;
    end
    #1;
    check("model_level",   32'(key_level),   32'(m_lvl));
    check("model_press",   32'(key_press),   32'(m_prs));
    check("model_release", 32'(key_release), 32'(m_rel));
    check("model_paused",  32'(paused),      32'(m_paused));
  endtask

  task automatic idle(input int n);
    for (int k = 0; k < n; k++) step();
  endtask

  initial begin
    int  lat;
    logic seen;
    logic p_before;
    logic [NK-1:0] pr;

    m_h1 = '1; m_h2 = '1; m_lvl = '0; m_prs = '0; m_rel = '0; m_paused = 1'b0;
    for (int k = 0; k < NK; k++) m_run[k] = 0;

    // 1: reset, outputs stay quiet with keys released
    reset = 1'b1; key_n = 3'b111;
    idle(2);
    reset = 1'b0;
    seen = 1'b0;
    for (int k = 0; k < 20; k++) begin
      step();
      if (key_level != 0 || key_press != 0 || key_release != 0 || paused != 0) seen = 1'b1;
    end
    check("reset_quiet", 32'(seen), 32'd0);
    check("reset_level", 32'(key_level), 32'd0);

    // 2: clean press/release on key0, 6-cycle latency, single-cycle pulse
    key_n[0] = 1'b0;
    lat = 0;
    for (int k = 1; k <= 20; k++) begin
      step();
      if (key_press[0]) begin lat = k; break; end
    end
    check("press_latency", 32'(lat), 32'd6);
    check("press_level", 32'(key_level[0]), 32'd1);
    step();
    check("press_one_cycle", 32'(key_press[0]), 32'd0);
    idle(3);
    key_n[0] = 1'b1;
    lat = 0;
    for (int k = 1; k <= 20; k++) begin
      step();
      if (key_release[0]) begin lat = k; break; end
    end
    check("release_latency", 32'(lat), 32'd6);
    check("release_level", 32'(key_level[0]), 32'd0);
    idle(8);

    // 3: bounce shorter than the debounce window is ignored
    seen = 1'b0;
    for (int k = 0; k < 20; k++) begin
      key_n[0] = (k < 3 || (k >= 4 && k < 7)) ? 1'b0 : 1'b1;
      step();
      if (key_level[0] || key_press[0]) seen = 1'b1;
    end
    check("bounce_reject", 32'(seen), 32'd0);

    // 4: pause toggles once per press, holding does not re-toggle
    key_n[1] = 1'b0; idle(10); key_n[1] = 1'b1; idle(10);
    check("pause_first", 32'(paused), 32'd1);
    key_n[1] = 1'b0; idle(10); key_n[1] = 1'b1; idle(10);
    check("pause_second", 32'(paused), 32'd0);
    key_n[1] = 1'b0; idle(50);
    check("pause_hold", 32'(paused), 32'd1);
    key_n[1] = 1'b1; idle(10);
    check("pause_hold_rel", 32'(paused), 32'd1);

    // 5: key0 and key2 on the same edge pulse together; paused untouched
    p_before = paused;
    key_n = 3'b010;
    pr = '0;
    for (int k = 0; k < 20; k++) begin
      step();
      if (key_press != 0) begin pr = key_press; break; end
    end
    check("simul_press", 32'(pr), 32'h5);
    step();
    check("simul_paused", 32'(paused), 32'(p_before));
    key_n = 3'b111; idle(10);

    // 6: reset during PRESS_W discards the wait; held key re-debounces from reset release
    key_n[0] = 1'b0;
    idle(5);
    reset = 1'b1;
    seen = 1'b0;
    for (int k = 0; k < 2; k++) begin
      step();
      if (key_press != 0 || key_level != 0) seen = 1'b1;
    end
    check("reset_mid_nopulse", 32'(seen), 32'd0);
    reset = 1'b0;
    lat = 0;
    for (int k = 1; k <= 20; k++) begin
      step();
      if (key_press[0]) begin lat = k; break; end
    end
    check("reset_mid_latency", 32'(lat), 32'd6);
    key_n = 3'b111; idle(10);

    // Random key activity with occasional resets, model-checked every cycle
    for (int c = 0; c < 4000; c++) begin
      if ($urandom_range(0, 5) == 0) key_n[$urandom_range(0, NK - 1)] ^= 1'b1;
      reset = ($urandom_range(0, 399) == 0);
      step();
    end
    reset = 1'b0;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
